// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit feeding the HiLo register (33 cycles per op).
// Define MULT_DIV_UNIT_DIV_EN to build the restoring divider; without it DIV/DIVU complete at once with no write.
module mult_div_unit (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start,
    input  logic [1:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic        Done,
    output logic        HiLoEn,
    output logic [63:0] HiLoWrite
);

    localparam int unsigned W     = 32;
    localparam int unsigned DW    = 64;
    localparam int unsigned CNT_W = 6;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [W-1:0]      opnd_q;
    logic [W-1:0]      hi_q;
    logic [W-1:0]      lo_q;
    logic              neg_prod_q;

    logic              is_signed_c;
    logic              is_div_c;
    logic              neg_prod_c;
    logic [W-1:0]      mag_a_c;
    logic [W-1:0]      mag_b_c;
    logic [W:0]        sum_c;
    logic [W-1:0]      hi_step_c;
    logic [W-1:0]      lo_step_c;
    logic [DW-1:0]     prod_c;
    logic [DW-1:0]     res_c;

`ifdef MULT_DIV_UNIT_DIV_EN
    logic              is_div_q;
    logic              neg_quo_q;
    logic              neg_rem_q;
    logic [W:0]        shifted_c;
`endif

    assign is_signed_c = ~Op[0];
    assign is_div_c    = Op[1];
    assign neg_prod_c  = is_signed_c & (A[W-1] ^ B[W-1]);
    assign mag_a_c     = (is_signed_c && A[W-1]) ? W'(-A) : A;
    assign mag_b_c     = (is_signed_c && B[W-1]) ? W'(-B) : B;

    // One radix-2 step on {hi_q, lo_q}: shift-add for multiply, restoring shift-subtract for divide
    always_comb begin
        sum_c     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        hi_step_c = sum_c[W:1];
        lo_step_c = {sum_c[0], lo_q[W-1:1]};
`ifdef MULT_DIV_UNIT_DIV_EN
        shifted_c = {hi_q, lo_q[W-1]};
        if (is_div_q) begin
            if (shifted_c >= {1'b0, opnd_q}) begin
                hi_step_c = W'(shifted_c - {1'b0, opnd_q});
                lo_step_c = {lo_q[W-2:0], 1'b1};
            end else begin
                hi_step_c = shifted_c[W-1:0];
                lo_step_c = {lo_q[W-2:0], 1'b0};
            end
        end
`endif
    end

    // Sign correction of the final magnitude result
    always_comb begin
        prod_c = {hi_step_c, lo_step_c};
        res_c  = neg_prod_q ? DW'(-prod_c) : prod_c;
`ifdef MULT_DIV_UNIT_DIV_EN
        if (is_div_q) begin
            res_c = {(neg_rem_q ? W'(-hi_step_c) : hi_step_c),
                     (neg_quo_q ? W'(-lo_step_c) : lo_step_c)};
        end
`endif
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state      <= IDLE;
            cnt        <= '0;
            opnd_q     <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            neg_prod_q <= 1'b0;
`ifdef MULT_DIV_UNIT_DIV_EN
            is_div_q   <= 1'b0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
`endif
            Busy       <= 1'b0;
            Done       <= 1'b0;
            HiLoEn     <= 1'b0;
            HiLoWrite  <= '0;
        end else begin
            Done   <= 1'b0;
            HiLoEn <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (Start) begin
                        cnt  <= '0;
                        hi_q <= '0;
`ifdef MULT_DIV_UNIT_DIV_EN
                        // A divide by zero keeps the raw all-ones quotient
                        is_div_q   <= is_div_c;
                        neg_prod_q <= neg_prod_c;
                        neg_quo_q  <= neg_prod_c & (B != '0);
                        neg_rem_q  <= is_signed_c & A[W-1];
                        opnd_q     <= is_div_c ? mag_b_c : mag_a_c;
                        lo_q       <= is_div_c ? mag_a_c : mag_b_c;
                        Busy       <= 1'b1;
                        state      <= RUN;
`else
                        if (is_div_c) begin
                            Done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            neg_prod_q <= neg_prod_c;
                            opnd_q     <= mag_a_c;
                            lo_q       <= mag_b_c;
                            Busy       <= 1'b1;
                            state      <= RUN;
                        end
`endif
                    end
                end
                RUN: begin
                    hi_q <= hi_step_c;
                    lo_q <= lo_step_c;
                    cnt  <= cnt + CNT_W'(1);
                    if (cnt == LAST_STEP) begin
                        Busy      <= 1'b0;
                        Done      <= 1'b1;
                        HiLoEn    <= 1'b1;
                        HiLoWrite <= res_c;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized self-checking bench for mult_div_unit against a transaction-level arithmetic model.
module tb_mult_div_unit;

`ifdef MULT_DIV_UNIT_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic        Done;
    logic        HiLoEn;
    logic [63:0] HiLoWrite;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    mult_div_unit dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B),
        .Busy(Busy), .Done(Done), .HiLoEn(HiLoEn), .HiLoWrite(HiLoWrite)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of one operation, straight from the arithmetic definitions
    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        logic [63:0]     res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            2'b00: res = 64'(sa * sb);
            2'b01: res = ua * ub;
            default: begin
                if (b == 32'd0) begin
                    res = {a, 32'hFFFF_FFFF};
                end else if (op == 2'b10) begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end else begin
                    uq = ua / ub;
                    ur = ua % ub;
                    res = {ur[31:0], uq[31:0]};
                end
            end
        endcase
        return res;
    endfunction

    // Cycle timeline model: accepted op is busy for 32 cycles, then a one-cycle completion
    int          m_ph = 0;
    int          m_left = 0;
    logic [63:0] m_pend = '0;
    logic        e_busy = 1'b0;
    logic        e_done = 1'b0;
    logic        e_en = 1'b0;
    logic [63:0] e_hilo = '0;

    always @(posedge Clk) begin
        if (Rst) begin
            m_ph = 0; m_left = 0;
            e_busy = 1'b0; e_done = 1'b0; e_en = 1'b0; e_hilo = '0;
        end else begin
            e_done = 1'b0;
            e_en   = 1'b0;
            case (m_ph)
                0: if (Start) begin
                    if (Op[1] && !DIV_ON) begin
                        e_done = 1'b1;
                        m_ph   = 2;
                    end else begin
                        m_pend = ref_result(Op, A, B);
                        m_left = 32;
                        e_busy = 1'b1;
                        m_ph   = 1;
                    end
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin
                        e_busy = 1'b0; e_done = 1'b1; e_en = 1'b1; e_hilo = m_pend;
                        m_ph = 2;
                    end
                end
                default: m_ph = 0;
            endcase
        end
    end

    always @(negedge Clk) begin
        if (chk_en) begin
            check("busy",   64'(Busy),   64'(e_busy));
            check("done",   64'(Done),   64'(e_done));
            check("hiloen", 64'(HiLoEn), 64'(e_en));
            check("hilo",   HiLoWrite,   e_hilo);
        end
    end

    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input bit chk_exp);
        int nb;
        bit seen;
        bit stub;
        stub = op[1] && !DIV_ON;
        @(posedge Clk); #1;
        Start = 1'b1; Op = op; A = a; B = b;
        nb = 0; seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge Clk); #1;
            Start = 1'($urandom); Op = 2'($urandom); A = $urandom; B = $urandom;
            @(negedge Clk);
            if (Busy) nb++;
            if (Done) begin
                seen  = 1'b1;
                Start = 1'b0;
            end
        end
        Start = 1'b0;
        check({name, "_done_seen"}, 64'(seen), 64'd1);
        if (seen) begin
            check({name, "_busy_cycles"}, 64'(nb), stub ? 64'd0 : 64'd32);
            check({name, "_en"}, 64'(HiLoEn), stub ? 64'd0 : 64'd1);
            if (chk_exp) check({name, "_result"}, HiLoWrite, exp);
        end
    endtask

    function automatic logic [31:0] pick_val(input int sel);
        case (sel)
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [63:0] last;
        logic [1:0]  rop;
        Rst = 1'b1; Start = 1'b0; Op = 2'b00; A = '0; B = '0;
        @(posedge Clk); #1;
        chk_en = 1'b1;
        @(posedge Clk); #1;
        Rst = 1'b0;

        check("pin_multu_max", ref_result(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
        check("pin_mult_neg",  ref_result(2'b00, 32'hFFFF_FFFD, 32'h0000_0007), 64'hFFFF_FFFF_FFFF_FFEB);
        check("pin_div_neg",   ref_result(2'b10, 32'hFFFF_FFF9, 32'h0000_0002), 64'hFFFF_FFFF_FFFF_FFFD);
        check("pin_div_ovf",   ref_result(2'b10, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);
        check("pin_divu_zero", ref_result(2'b11, 32'd100, 32'd0),               64'h0000_0064_FFFF_FFFF);
        check("pin_div_zero",  ref_result(2'b10, 32'hFFFF_FFF0, 32'd0),         64'hFFFF_FFF0_FFFF_FFFF);
        check("pin_multu_3x5", ref_result(2'b01, 32'd3, 32'd5),                 64'h0000_0000_0000_000F);

        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1);
        last = 64'hFFFF_FFFF_FFFF_FFEB;
        run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'h0000_0007, last, 1'b1);
        run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002,
               DIV_ON ? 64'hFFFF_FFFF_FFFF_FFFD : last, 1'b1);
        if (DIV_ON) last = 64'hFFFF_FFFF_FFFF_FFFD;
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF,
               DIV_ON ? 64'h0000_0000_8000_0000 : last, 1'b1);
        if (DIV_ON) last = 64'h0000_0000_8000_0000;
        run_op("divu_zero", 2'b11, 32'd100, 32'd0,
               DIV_ON ? 64'h0000_0064_FFFF_FFFF : last, 1'b1);
        run_op("multu_3x5", 2'b01, 32'd3, 32'd5, 64'h0000_0000_0000_000F, 1'b1);

        // Reset in the middle of a run with Start held high
        @(posedge Clk); #1;
        Start = 1'b1; Op = 2'b01; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF;
        repeat (10) begin
            @(posedge Clk); #1;
        end
        Rst = 1'b1;
        @(posedge Clk); #1;
        Rst = 1'b0; Start = 1'b0;
        @(negedge Clk);
        check("abort_busy",   64'(Busy),   64'd0);
        check("abort_hiloen", 64'(HiLoEn), 64'd0);
        check("abort_hilo",   HiLoWrite,   64'd0);
        run_op("post_abort", 2'b01, 32'd3, 32'd5, 64'h0000_0000_0000_000F, 1'b1);

        for (int n = 0; n < 30; n++) begin
            rop = 2'($urandom);
            run_op("rand", rop, pick_val(int'($urandom_range(0, 6))),
                   pick_val(int'($urandom_range(0, 6))), 64'd0, 1'b0);
        end

        repeat (3) @(posedge Clk);
        @(negedge Clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
